// File: rtl/fp_pkg.sv
// ============================================================================
//  Module   : fp_pkg
//  Purpose  : Fixed-point word type, dendrite FSM states and fit helper.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

  localparam int FP_W = 16;

  // Native signed fixed-point word
  typedef logic signed [FP_W-1:0] fpType;

  // Extra accumulator headroom bit on top of the log2 term count
  localparam int ACC_GUARD = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    DECAY  = 3'd2,
    COUPLE = 3'd3,
    COMMIT = 3'd4
  } dc_state_t;

  // Clamp a sign-extended value into the signed range of a w-bit word
  function automatic logic signed [63:0] sat_fit(input logic signed [63:0] x,
                                                 input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi)
      return hi;
    else if (x < lo)
      return lo;
    else
      return x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_shift_fit.sv
// ============================================================================
//  Module   : fp_shift_fit
//  Purpose  : Arithmetic right shift of a wide signed value, then fit to OUT_W
//             bits (clamp when DENDRITE_SAT_EN is defined, else wrap).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fp_shift_fit
  import fp_pkg::*;
#(
  parameter int IN_W  = 34,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  i_value,
  output logic signed [OUT_W-1:0] o_value
);

`ifdef DENDRITE_SAT_EN
  assign o_value = OUT_W'(sat_fit(64'(i_value >>> SHIFT), OUT_W));
`else
  assign o_value = OUT_W'(i_value >>> SHIFT);
`endif

endmodule

`default_nettype wire

// File: rtl/dendrite_compartment_seq.sv
// ============================================================================
//  Module   : dendrite_compartment_seq
//  Purpose  : Time-multiplexed dendrite compartment: one shared accumulator and
//             one shared multiplier integrate synapses, leak and upper current.
//             Macro DENDRITE_SAT_EN selects saturating (vs wrapping) fit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dendrite_compartment_seq
  import fp_pkg::*;
#(
  parameter int W           = FP_W,
  parameter int N_SYN       = 4,
  parameter int SHIFT_DECAY = 15,
  parameter int SHIFT_LOWER = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step,
  input  logic [N_SYN*W-1:0]   syn_current,
  input  logic signed [W-1:0]  E_l,
  input  logic signed [W-1:0]  upper_current,
  input  logic signed [W-1:0]  lower_vmem,
  output logic signed [W-1:0]  upper_vmem,
  output logic signed [W-1:0]  lower_current,
  output logic                 busy,
  output logic                 done,
  output logic                 step_overrun,
  input  logic                 cfg_valid,
  input  logic [W-1:0]         cfg_data_in,
  output logic [W-1:0]         cfg_data_out
);

  localparam int C_ACC_W  = W + $clog2(N_SYN + 2) + ACC_GUARD;
  localparam int C_IDX_W  = (N_SYN > 1) ? $clog2(N_SYN) : 1;
  localparam int C_PROD_W = 2 * W + 2;
  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(N_SYN - 1);

  dc_state_t r_state;
  dc_state_t w_next_state;

  logic [C_IDX_W-1:0]         r_idx;
  logic signed [C_ACC_W-1:0]  r_acc;
  logic signed [W-1:0]        r_vmem;
  logic signed [W-1:0]        r_lower_cur;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_overrun;
  logic [W-1:0]               r_tau;
  logic [W-1:0]               r_g_int;
  logic [W-1:0]               r_cfg_out;

  logic [N_SYN*W-1:0]         r_syn_snap;
  logic signed [W-1:0]        r_el_snap;
  logic signed [W-1:0]        r_upper_snap;
  logic signed [W-1:0]        r_lvm_snap;
  logic [W-1:0]               r_tau_snap;
  logic [W-1:0]               r_g_snap;
  logic signed [W-1:0]        r_vmem_snap;

  logic signed [W-1:0]        w_syn [N_SYN];
  logic signed [W:0]          w_mul_a;
  logic signed [W:0]          w_mul_b;
  logic signed [C_PROD_W-1:0] w_prod;
  logic signed [C_ACC_W-1:0]  w_decay;
  logic signed [C_ACC_W-1:0]  w_addend;
  logic signed [C_ACC_W-1:0]  w_sum;
  logic signed [W-1:0]        w_vmem_fit;
  logic signed [W-1:0]        w_lower_fit;

  for (genvar gi = 0; gi < N_SYN; gi++) begin : g_syn
    assign w_syn[gi] = r_syn_snap[gi*W +: W];
  end

  // Shared multiplier: leak product in DECAY, coupling product in COMMIT
  always_comb begin
    w_mul_a = (W+1)'(r_el_snap) - (W+1)'(r_vmem_snap);
    w_mul_b = {1'b0, r_tau_snap};
    if (r_state == COMMIT) begin
      w_mul_a = (W+1)'(r_vmem_snap) - (W+1)'(r_lvm_snap);
      w_mul_b = {1'b0, r_g_snap};
    end
  end

  assign w_prod = w_mul_a * w_mul_b;

  fp_shift_fit #(
    .IN_W  (C_PROD_W),
    .OUT_W (C_ACC_W),
    .SHIFT (SHIFT_DECAY)
  ) u_decay_fit (
    .i_value (w_prod),
    .o_value (w_decay)
  );

  fp_shift_fit #(
    .IN_W  (C_PROD_W),
    .OUT_W (W),
    .SHIFT (SHIFT_LOWER)
  ) u_lower_fit (
    .i_value (w_prod),
    .o_value (w_lower_fit)
  );

  fp_shift_fit #(
    .IN_W  (C_ACC_W),
    .OUT_W (W),
    .SHIFT (0)
  ) u_vmem_fit (
    .i_value (r_acc),
    .o_value (w_vmem_fit)
  );

  // Shared adder operand select
  always_comb begin
    w_addend = C_ACC_W'(w_syn[r_idx]);
    case (r_state)
      DECAY:   w_addend = w_decay;
      COUPLE:  w_addend = C_ACC_W'(r_upper_snap);
      default: ;
    endcase
  end

  assign w_sum = r_acc + w_addend;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (step) w_next_state = ACCUM;
      ACCUM:   if (r_idx == C_LAST_IDX) w_next_state = DECAY;
      DECAY:   w_next_state = COUPLE;
      COUPLE:  w_next_state = COMMIT;
      COMMIT:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_acc        <= '0;
      r_vmem       <= '0;
      r_lower_cur  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_tau        <= '0;
      r_g_int      <= '0;
      r_cfg_out    <= '0;
      r_syn_snap   <= '0;
      r_el_snap    <= '0;
      r_upper_snap <= '0;
      r_lvm_snap   <= '0;
      r_tau_snap   <= '0;
      r_g_snap     <= '0;
      r_vmem_snap  <= '0;
    end else begin
      r_done <= 1'b0;

      if (cfg_valid) begin
        r_tau     <= cfg_data_in;
        r_g_int   <= r_tau;
        r_cfg_out <= r_g_int;
      end

      if (step && r_busy)
        r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (step) begin
            r_syn_snap   <= syn_current;
            r_el_snap    <= E_l;
            r_upper_snap <= upper_current;
            r_lvm_snap   <= lower_vmem;
            r_tau_snap   <= r_tau;
            r_g_snap     <= r_g_int;
            r_vmem_snap  <= r_vmem;
            r_acc        <= C_ACC_W'(r_vmem);
            r_idx        <= '0;
            r_busy       <= 1'b1;
          end
        end
        ACCUM: begin
          r_acc <= w_sum;
          r_idx <= r_idx + 1'b1;
        end
        DECAY, COUPLE: r_acc <= w_sum;
        COMMIT: begin
          r_vmem      <= w_vmem_fit;
          r_lower_cur <= w_lower_fit;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign upper_vmem    = r_vmem;
  assign lower_current = r_lower_cur;
  assign busy          = r_busy;
  assign done          = r_done;
  assign step_overrun  = r_overrun;
  assign cfg_data_out  = r_cfg_out;

endmodule

`default_nettype wire

// File: tb/tb_dendrite_compartment_seq.sv
// ============================================================================
//  Module   : tb_dendrite_compartment_seq
//  Purpose  : Directed and randomized checks of dendrite_compartment_seq
//             against an arithmetic reference model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dendrite_compartment_seq;
  import fp_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           step;
  logic [N*W-1:0] syn_current;
  fpType          E_l;
  fpType          upper_current;
  fpType          lower_vmem;
  fpType          upper_vmem;
  fpType          lower_current;
  logic           busy;
  logic           done;
  logic           step_overrun;
  logic           cfg_valid;
  logic [W-1:0]   cfg_data_in;
  logic [W-1:0]   cfg_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  longint m_vmem, m_lower, m_tau, m_g, m_cfg_out;
  logic   m_overrun;

  always #5 clk = ~clk;

  dendrite_compartment_seq #(
    .W(W), .N_SYN(N), .SHIFT_DECAY(15), .SHIFT_LOWER(9)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .step          (step),
    .syn_current   (syn_current),
    .E_l           (E_l),
    .upper_current (upper_current),
    .lower_vmem    (lower_vmem),
    .upper_vmem    (upper_vmem),
    .lower_current (lower_current),
    .busy          (busy),
    .done          (done),
    .step_overrun  (step_overrun),
    .cfg_valid     (cfg_valid),
    .cfg_data_in   (cfg_data_in),
    .cfg_data_out  (cfg_data_out)
  );

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint fit_m(input longint x);
`ifdef DENDRITE_SAT_EN
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
`else
    longint r;
    r = x % 65536;
    if (r < 0) r += 65536;
    if (r >= 32768) r -= 65536;
    return r;
`endif
  endfunction

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // One integration update of the reference model
  task automatic model_step(input logic [N*W-1:0] syn, input fpType el,
                            input fpType up, input fpType lv);
    longint acc;
    longint vsnap;
    fpType  s;
    vsnap = m_vmem;
    acc = vsnap + longint'(up);
    for (int i = 0; i < N; i++) begin
      s = syn[i*W +: W];
      acc += longint'(s);
    end
    acc += floor_div((longint'(el) - vsnap) * m_tau, 32768);
    m_vmem  = fit_m(acc);
    m_lower = fit_m(floor_div((vsnap - longint'(lv)) * m_g, 512));
  endtask

  task automatic model_reset();
    m_vmem = 0; m_lower = 0; m_tau = 0; m_g = 0; m_cfg_out = 0; m_overrun = 1'b0;
  endtask

  task automatic cfg_shift(input logic [W-1:0] v);
    cfg_valid   = 1'b1;
    cfg_data_in = v;
    @(negedge clk);
    cfg_valid = 1'b0;
    m_cfg_out = m_g;
    m_g       = m_tau;
    m_tau     = longint'(v);
  endtask

  task automatic set_cfg(input logic [W-1:0] tau, input logic [W-1:0] g);
    cfg_shift(g);
    cfg_shift(tau);
    check_val("cfg_out", cfg_data_out, m_cfg_out);
  endtask

  task automatic scramble_inputs();
    syn_current   = {$urandom, $urandom};
    E_l           = fpType'($urandom);
    upper_current = fpType'($urandom);
    lower_vmem    = fpType'($urandom);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle
  task automatic run_step(input logic [N*W-1:0] syn, input fpType el,
                          input fpType up, input fpType lv, input string tag);
    int   lat;
    logic busy_ok;
    logic seen;
    step = 1'b1; syn_current = syn; E_l = el; upper_current = up; lower_vmem = lv;
    model_step(syn, el, up, lv);
    @(negedge clk);
    step = 1'b0;
    scramble_inputs();
    busy_ok = 1'b1; seen = 1'b0; lat = 0;
    for (int j = 0; j < 20 && !seen; j++) begin
      if (done) begin
        seen = 1'b1;
        lat  = j;
      end else begin
        if (!busy) busy_ok = 1'b0;
        @(negedge clk);
      end
    end
    check_val({tag, " done"}, seen, 1);
    check_val({tag, " latency"}, lat, 7);
    check_val({tag, " busy_during"}, busy_ok, 1);
    check_val({tag, " busy_at_done"}, busy, 0);
    check_val({tag, " vmem"}, upper_vmem, m_vmem);
    check_val({tag, " lower"}, lower_current, m_lower);
    check_val({tag, " overrun"}, step_overrun, m_overrun);
  endtask

  // Drive vmem to target with tau=0 by spreading the difference over inputs
  task automatic set_vmem(input longint target, input string tag);
    longint diff, q;
    logic [N*W-1:0] syn;
    diff = target - m_vmem;
    q    = diff / 5;
    for (int i = 0; i < N; i++) syn[i*W +: W] = 16'(q);
    run_step(syn, fpType'(0), fpType'(diff - 4 * q), fpType'(0), tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [N*W-1:0] syn;

    reset = 1'b1; step = 1'b1; cfg_valid = 1'b0; cfg_data_in = '0;
    syn_current = '0; E_l = '0; upper_current = '0; lower_vmem = '0;
    model_reset();

    // Reset with step held high
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) cnt++;
    end
    reset = 1'b0; step = 1'b0;
    check_val("rst vmem", upper_vmem, 0);
    check_val("rst lower", lower_current, 0);
    check_val("rst busy", busy, 0);
    check_val("rst done", done, 0);
    check_val("rst overrun", step_overrun, 0);
    check_val("rst cfg_out", cfg_data_out, 0);
    repeat (10) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check_val("rst no_done", cnt, 0);

    // Config chain
    cfg_shift(16'h0011);
    cfg_shift(16'h0022);
    cfg_shift(16'h4000);
    check_val("cfg chain out", cfg_data_out, 16'h0011);

    // Basic synapse sum
    set_cfg(16'd0, 16'd0);
    syn = {16'sd0, -16'sd5, 16'sd20, 16'sd10};
    run_step(syn, fpType'(0), fpType'(0), fpType'(0), "t3");
    check_val("t3 const", upper_vmem, 25);

    // Leak and coupling
    set_vmem(1000, "t4 set");
    set_cfg(16'd16384, 16'd0);
    run_step('0, fpType'(0), fpType'(0), fpType'(0), "t4 leak");
    check_val("t4 leak const", upper_vmem, 500);
    set_cfg(16'd0, 16'd512);
    set_vmem(512, "t4 set2");
    run_step('0, fpType'(0), fpType'(0), fpType'(0), "t4 couple");
    check_val("t4 couple const", lower_current, 512);

    // Overflow at the fit boundary
    set_cfg(16'd0, 16'd0);
    set_vmem(32000, "t5 set");
    syn = '0; syn[15:0] = 16'd1000;
    run_step(syn, fpType'(0), fpType'(0), fpType'(0), "t5");
`ifdef DENDRITE_SAT_EN
    check_val("t5 const", upper_vmem, 32767);
`else
    check_val("t5 const", upper_vmem, -32536);
`endif

    // Hold without step
    repeat (6) @(negedge clk);
    check_val("hold vmem", upper_vmem, m_vmem);
    check_val("hold lower", lower_current, m_lower);

    // Randomized updates, back-to-back steps in the done cycle
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(2) == 0)
        set_cfg(16'($urandom), 16'($urandom));
      run_step({$urandom, $urandom}, fpType'($urandom), fpType'($urandom),
               fpType'($urandom), "rand");
    end

    // Step while busy
    syn = {$urandom, $urandom};
    step = 1'b1; syn_current = syn; E_l = fpType'(123); upper_current = fpType'(-77);
    lower_vmem = fpType'(300);
    model_step(syn, fpType'(123), fpType'(-77), fpType'(300));
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    scramble_inputs();
    @(negedge clk);
    step = 1'b0;
    m_overrun = 1'b1;
    cnt = 0;
    repeat (15) begin
      if (done) cnt++;
      @(negedge clk);
    end
    check_val("ovr dones", cnt, 1);
    check_val("ovr flag", step_overrun, 1);
    check_val("ovr vmem", upper_vmem, m_vmem);
    check_val("ovr lower", lower_current, m_lower);

    // Reset in the middle of ACCUM
    step = 1'b1; syn_current = {$urandom, $urandom};
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cnt = 0;
    repeat (12) begin
      if (done) cnt++;
      @(negedge clk);
    end
    check_val("abort no_done", cnt, 0);
    check_val("abort vmem", upper_vmem, 0);
    check_val("abort busy", busy, 0);
    check_val("abort overrun", step_overrun, 0);
    check_val("abort lower", lower_current, 0);

    run_step({$urandom, $urandom}, fpType'($urandom), fpType'($urandom),
             fpType'($urandom), "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
